// File: rtl/sl_receiver.sv
// sl_receiver: receive side of the two-wire SL serial link.
// Decodes the (SL0,SL1) level pair into words of 8..32 data bits plus an odd
// parity bit and a stop marker. The decoder follows line codes rather than
// bit timing, so it works for any transmitter rate within the filter limits.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   SL0, SL1     SL line pair, asynchronous to clk
//   d_in         write data from master
//   addr         0 = {status[15:0], config[15:0]}, 1 = rx data (read-only)
//   wr_en        single-cycle write strobe
//   d_out        combinational read mux selected by addr
//   irq          registered interrupt request (IRQM & any sticky IRQ flag)
module sl_receiver #(
  parameter int unsigned FILT_LEN = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SL0,
  input  logic        SL1,
  input  logic [31:0] d_in,
  input  logic        addr,
  input  logic        wr_en,
  output logic [31:0] d_out,
  output logic        irq
);

  localparam int unsigned DW = 32;      // max data bits
  localparam int unsigned SW = DW + 1;  // data plus parity
  localparam int unsigned CW = 6;       // bit counter / BQ width
  localparam int unsigned FW = 3;       // filter run counter width
  localparam int unsigned TW = 8;       // timeout counter width
  localparam int unsigned NF = 5;       // number of IRQ flags

  localparam logic [1:0] CODE_IDLE = 2'b11;
  localparam logic [1:0] CODE_ONE  = 2'b10;
  localparam logic [1:0] CODE_ZERO = 2'b01;
  localparam logic [1:0] CODE_STOP = 2'b00;

  // IRQ flag positions within irqf (status bits 8..12)
  localparam int unsigned F_RM = 0;
  localparam int unsigned F_PE = 1;
  localparam int unsigned F_LE = 2;
  localparam int unsigned F_OV = 3;
  localparam int unsigned F_IC = 4;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_BIT   = 5'b00010,
    S_SPACE = 5'b00100,
    S_STOP  = 5'b01000,
    S_ERR   = 5'b10000
  } state_e;

  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]    last_q, last_d, acc_q, acc_d;
  logic [FW-1:0] run_q, run_d;
  logic          chg_q, chg_d;
  state_e        state_q, state_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] bq_lat_q, bq_lat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rxen_q, rxen_d;
  logic [CW-1:0] bq_q, bq_d;
  logic          irqm_q, irqm_d;
  logic          rip_q, rip_d;
  logic [NF-1:0] irqf_q, irqf_d;
  logic [DW-1:0] rx_q, rx_d;
  logic          irq_q, irq_d;

  logic [NF-1:0] set_c;
  logic [NF-1:0] keep_c;
  logic [DW-1:0] rx_load_c;
  logic [CW-1:0] bq_w_c;
  logic          cfg_ok_c;
  logic          bit_c;
  logic          tmo_hit_c;
  logic          unused_din_c;

  assign unused_din_c = ^{d_in[31:29], d_in[23:16], d_in[15:8]};

  // Synchronizer and glitch filter: a code is accepted after FILT_LEN equal samples
  always_comb begin
    sync1_d = {SL0, SL1};
    sync2_d = sync1_q;
    last_d  = sync2_q;
    if (sync2_q == last_q) begin
      run_d = (run_q == FW'(FILT_LEN)) ? run_q : FW'(run_q + FW'(1));
    end else begin
      run_d = FW'(1);
    end
    chg_d = (run_d == FW'(FILT_LEN)) && (sync2_q != acc_q);
    acc_d = chg_d ? sync2_q : acc_q;
  end

  // Received word masked to the latched bit count
  always_comb begin
    rx_load_c = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      rx_load_c[i] = shift_q[i] & (CW'(i) < bq_lat_q);
    end
  end

  // Decoder FSM, timeout, register port and sticky flags
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    bq_lat_d = bq_lat_q;
    rip_d    = rip_q;
    rx_d     = rx_q;
    rxen_d   = rxen_q;
    bq_d     = bq_q;
    irqm_d   = irqm_q;
    set_c    = '0;
    keep_c   = '1;
    bit_c    = (acc_q == CODE_ONE);

    // Timeout counts time spent on one code while a word is open
    if (chg_q || (state_q == S_IDLE) || (state_q == S_ERR)) begin
      tmo_d = '0;
    end else begin
      tmo_d = (tmo_q == '1) ? tmo_q : TW'(tmo_q + TW'(1));
    end
    tmo_hit_c = (tmo_q >= TW'(TIMEOUT)) &&
                ((state_q == S_BIT) || (state_q == S_SPACE) || (state_q == S_STOP));

    if (tmo_hit_c) begin
      state_d      = S_IDLE;
      rip_d        = 1'b0;
      set_c[F_LE]  = 1'b1;
    end else if (chg_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (acc_q == CODE_STOP) begin
            state_d = S_ERR;
          end else if (((acc_q == CODE_ONE) || (acc_q == CODE_ZERO)) && rxen_q) begin
            state_d    = S_BIT;
            bq_lat_d   = bq_q;
            shift_d    = '0;
            shift_d[0] = bit_c;
            cnt_d      = CW'(1);
            rip_d      = 1'b1;
          end
        end
        S_BIT: begin
          if (acc_q == CODE_IDLE) begin
            state_d = S_SPACE;
          end else begin
            state_d     = S_ERR;
            rip_d       = 1'b0;
            set_c[F_LE] = 1'b1;
          end
        end
        S_SPACE: begin
          if (acc_q == CODE_STOP) begin
            state_d = S_STOP;
          end else if (acc_q != CODE_IDLE) begin
            state_d = S_BIT;
            if (cnt_q <= CW'(DW)) begin
              shift_d[cnt_q] = bit_c;
            end
            cnt_d = (cnt_q == '1) ? cnt_q : CW'(cnt_q + CW'(1));
          end
        end
        S_STOP: begin
          rip_d = 1'b0;
          if (acc_q == CODE_IDLE) begin
            state_d = S_IDLE;
            if (cnt_q != CW'(bq_lat_q + CW'(1))) begin
              set_c[F_LE] = 1'b1;
            end else if (!(^shift_q)) begin
              set_c[F_PE] = 1'b1;
            end else begin
              rx_d        = rx_load_c;
              set_c[F_RM] = 1'b1;
              set_c[F_OV] = irqf_q[F_RM];
            end
          end else begin
            state_d     = S_ERR;
            set_c[F_LE] = 1'b1;
          end
        end
        S_ERR: begin
          if (acc_q == CODE_IDLE) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          rip_d   = 1'b0;
        end
      endcase
    end

    // Register write: config validation and write-zero-to-clear of IRQ flags
    bq_w_c   = d_in[6:1];
    cfg_ok_c = (bq_w_c >= CW'(8)) && (bq_w_c <= CW'(DW)) && !bq_w_c[0];
    if (wr_en && !addr) begin
      keep_c = d_in[28:24];
      if (cfg_ok_c) begin
        rxen_d = d_in[0];
        bq_d   = bq_w_c;
        irqm_d = d_in[7];
      end else begin
        set_c[F_IC] = 1'b1;
      end
    end

    // Set events win over a same-cycle clear
    irqf_d = (irqf_q & keep_c) | set_c;
    irq_d  = irqm_q & (|irqf_q);
  end

  // Read mux
  always_comb begin
    if (addr) begin
      d_out = rx_q;
    end else begin
      d_out = {3'b000, irqf_q, 7'b0000000, rip_q, 8'h00, irqm_q, bq_q, rxen_q};
    end
  end

  assign irq = irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= CODE_IDLE;
      sync2_q  <= CODE_IDLE;
      last_q   <= CODE_IDLE;
      acc_q    <= CODE_IDLE;
      run_q    <= FW'(FILT_LEN);
      chg_q    <= 1'b0;
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      bq_lat_q <= CW'(8);
      tmo_q    <= '0;
      rxen_q   <= 1'b1;
      bq_q     <= CW'(8);
      irqm_q   <= 1'b0;
      rip_q    <= 1'b0;
      irqf_q   <= '0;
      rx_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      last_q   <= last_d;
      acc_q    <= acc_d;
      run_q    <= run_d;
      chg_q    <= chg_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      bq_lat_q <= bq_lat_d;
      tmo_q    <= tmo_d;
      rxen_q   <= rxen_d;
      bq_q     <= bq_d;
      irqm_q   <= irqm_d;
      rip_q    <= rip_d;
      irqf_q   <= irqf_d;
      rx_q     <= rx_d;
      irq_q    <= irq_d;
    end
  end

endmodule
